// File: rtl/switch_cfg_arbiter_pkg.sv
// Shared types and address map for the switch-config arbiter.
// Optional read-back support is enabled with SWITCH_CFG_READBACK_EN.
package switch_cfg_arbiter_pkg;

  localparam int NODE_ID_W = 4;
  typedef logic [NODE_ID_W-1:0] node_id_t;

  typedef enum logic [1:0] {
    CFG_OK       = 2'd0,
    CFG_BAD_ADDR = 2'd1,
    CFG_RD_OK    = 2'd2
  } cfg_status_e;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    WRITE = 2'd1,
    RESP  = 2'd2
  } cfg_arb_state_e;

  localparam logic [7:0] CFG_ADDR_RT_LO    = 8'h01;
  localparam logic [7:0] CFG_ADDR_RT_HI    = 8'h0F;
  localparam logic [7:0] CFG_ADDR_DATELINE = 8'h15;

  // Route LUT entries plus the single dateline register are writable.
  function automatic logic cfg_addr_valid(input logic [31:0] addr);
    return ((addr >= 32'(CFG_ADDR_RT_LO)) && (addr <= 32'(CFG_ADDR_RT_HI))) ||
           (addr == 32'(CFG_ADDR_DATELINE));
  endfunction

endpackage

// File: rtl/switch_cfg_arbiter_if.sv
// Request / reg-bank / response bundle between input buffers and the config arbiter.
// SWITCH_CFG_READBACK_EN adds the read request and bank read-back signals.
interface switch_cfg_arbiter_if
  import switch_cfg_arbiter_pkg::*;
#(
  parameter int NUM_BUFFERS = 4,
  parameter int ADDR_W      = 8,
  parameter int DATA_W      = 15
);

  logic     [NUM_BUFFERS-1:0]             req_valid;
  logic     [NUM_BUFFERS-1:0][ADDR_W-1:0] req_addr;
  logic     [NUM_BUFFERS-1:0][DATA_W-1:0] req_data;
  node_id_t [NUM_BUFFERS-1:0]             req_src;
  logic     [NUM_BUFFERS-1:0]             req_ready;

  logic              wr_en;
  logic [ADDR_W-1:0] wr_addr;
  logic [DATA_W-1:0] wr_data;

  logic              resp_valid;
  logic              resp_ready;
  node_id_t          resp_dest;
  logic [ADDR_W-1:0] resp_addr;
  cfg_status_e       resp_status;
  logic              busy;

`ifdef SWITCH_CFG_READBACK_EN
  logic [NUM_BUFFERS-1:0] req_rd;
  logic [ADDR_W-1:0]      rd_addr;
  logic [DATA_W-1:0]      rd_data;
  logic [DATA_W-1:0]      resp_data;

  modport master (
    output req_valid, req_addr, req_data, req_src, req_rd, resp_ready, rd_data,
    input  req_ready, wr_en, wr_addr, wr_data, resp_valid, resp_dest, resp_addr,
           resp_status, busy, rd_addr, resp_data
  );

  modport slave (
    input  req_valid, req_addr, req_data, req_src, req_rd, resp_ready, rd_data,
    output req_ready, wr_en, wr_addr, wr_data, resp_valid, resp_dest, resp_addr,
           resp_status, busy, rd_addr, resp_data
  );
`else
  modport master (
    output req_valid, req_addr, req_data, req_src, resp_ready,
    input  req_ready, wr_en, wr_addr, wr_data, resp_valid, resp_dest, resp_addr,
           resp_status, busy
  );

  modport slave (
    input  req_valid, req_addr, req_data, req_src, resp_ready,
    output req_ready, wr_en, wr_addr, wr_data, resp_valid, resp_dest, resp_addr,
           resp_status, busy
  );
`endif

endinterface

// File: rtl/switch_cfg_arbiter_rr_arbiter.sv
// Round-robin arbiter: first requester at or after ptr wins, wrapping N-1 -> 0.
// Purely combinational so switch output allocators can reuse it.
module rr_arbiter #(
  parameter int N = 4,
  localparam int IDX_W = (N > 1) ? $clog2(N) : 1
) (
  input  logic [N-1:0]     req,
  input  logic [IDX_W-1:0] ptr,
  output logic [N-1:0]     grant,
  output logic [IDX_W-1:0] idx,
  output logic             any
);

  always_comb begin : scan
    int               k;
    logic [IDX_W-1:0] kk;
    grant = '0;
    idx   = '0;
    any   = 1'b0;
    k     = 0;
    kk    = '0;
    for (int i = 0; i < N; i++) begin
      // Wrap by subtraction so non-power-of-2 N never indexes past N-1.
      k = int'(ptr) + i;
      if (k >= N) k = k - N;
      kk = IDX_W'(k);
      if (!any && req[kk]) begin
        any       = 1'b1;
        grant[kk] = 1'b1;
        idx       = kk;
      end
    end
  end

endmodule

// File: rtl/switch_cfg_arbiter.sv
// Serialises switch-config requests from the input buffers onto the reg-bank write port.
// Optional read-back path compiled in with SWITCH_CFG_READBACK_EN.
//
//   state | meaning
//   IDLE  | waiting; grants one requester and latches its request
//   WRITE | one-cycle reg-bank access (write strobe or read capture)
//   RESP  | response held until resp_ready, then rr_ptr advances past the winner
module switch_cfg_arbiter
  import switch_cfg_arbiter_pkg::*;
#(
  parameter int NUM_BUFFERS = 4,
  parameter int ADDR_W      = 8,
  parameter int DATA_W      = 15
) (
  input logic                 clk,
  input logic                 n_rst,
  switch_cfg_arbiter_if.slave bus
);

  localparam int               IDX_W    = (NUM_BUFFERS > 1) ? $clog2(NUM_BUFFERS) : 1;
  localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(NUM_BUFFERS - 1);

  cfg_arb_state_e    state;
  logic [IDX_W-1:0]  rr_ptr;
  logic [IDX_W-1:0]  lat_idx;
  logic [ADDR_W-1:0] lat_addr;
  logic [DATA_W-1:0] lat_data;
  node_id_t          lat_src;
  logic              lat_ok;
  logic              wr_en_q;
  logic              resp_valid_q;
  cfg_status_e       status_q;
  logic              busy_q;

  logic [NUM_BUFFERS-1:0] gnt_onehot;
  logic [IDX_W-1:0]       gnt_idx;
  logic                   gnt_any;
  logic                   acc_ok;
  logic                   acc_rd;

`ifdef SWITCH_CFG_READBACK_EN
  logic              lat_rd;
  logic [DATA_W-1:0] resp_data_q;
`endif

  rr_arbiter #(.N(NUM_BUFFERS)) u_rr (
    .req   (bus.req_valid),
    .ptr   (rr_ptr),
    .grant (gnt_onehot),
    .idx   (gnt_idx),
    .any   (gnt_any)
  );

  // Accept pulse is combinational so the requester sees it in the grant cycle.
  assign bus.req_ready = (state == IDLE) ? gnt_onehot : '0;

  always_comb begin
    acc_ok = cfg_addr_valid(32'(bus.req_addr[gnt_idx]));
`ifdef SWITCH_CFG_READBACK_EN
    acc_rd = bus.req_rd[gnt_idx];
`else
    acc_rd = 1'b0;
`endif
  end

  always_ff @(posedge clk or negedge n_rst) begin
    if (!n_rst) begin
      state        <= IDLE;
      rr_ptr       <= '0;
      lat_idx      <= '0;
      lat_addr     <= '0;
      lat_data     <= '0;
      lat_src      <= '0;
      lat_ok       <= 1'b0;
      wr_en_q      <= 1'b0;
      resp_valid_q <= 1'b0;
      status_q     <= CFG_OK;
      busy_q       <= 1'b0;
`ifdef SWITCH_CFG_READBACK_EN
      lat_rd       <= 1'b0;
      resp_data_q  <= '0;
`endif
    end else begin
      case (state)
        IDLE: begin
          if (gnt_any) begin
            lat_idx  <= gnt_idx;
            lat_addr <= bus.req_addr[gnt_idx];
            lat_data <= bus.req_data[gnt_idx];
            lat_src  <= bus.req_src[gnt_idx];
            lat_ok   <= acc_ok;
            wr_en_q  <= acc_ok && !acc_rd;
            busy_q   <= 1'b1;
            state    <= WRITE;
`ifdef SWITCH_CFG_READBACK_EN
            lat_rd   <= acc_rd;
`endif
          end
        end
        WRITE: begin
          wr_en_q      <= 1'b0;
          resp_valid_q <= 1'b1;
          state        <= RESP;
`ifdef SWITCH_CFG_READBACK_EN
          if (!lat_ok) begin
            status_q    <= CFG_BAD_ADDR;
            resp_data_q <= '0;
          end else if (lat_rd) begin
            status_q    <= CFG_RD_OK;
            resp_data_q <= bus.rd_data;
          end else begin
            status_q    <= CFG_OK;
            resp_data_q <= '0;
          end
`else
          status_q     <= lat_ok ? CFG_OK : CFG_BAD_ADDR;
`endif
        end
        RESP: begin
          if (bus.resp_ready) begin
            resp_valid_q <= 1'b0;
            busy_q       <= 1'b0;
            rr_ptr       <= (lat_idx == LAST_IDX) ? '0 : lat_idx + IDX_W'(1);
            state        <= IDLE;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

  assign bus.wr_en       = wr_en_q;
  assign bus.wr_addr     = lat_addr;
  assign bus.wr_data     = lat_data;
  assign bus.resp_valid  = resp_valid_q;
  assign bus.resp_dest   = lat_src;
  assign bus.resp_addr   = lat_addr;
  assign bus.resp_status = status_q;
  assign bus.busy        = busy_q;
`ifdef SWITCH_CFG_READBACK_EN
  assign bus.rd_addr     = lat_addr;
  assign bus.resp_data   = resp_data_q;
`endif

endmodule
